// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] XZR = 5'd31;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter for the hazard performance counters.
// Only present in builds with HAZARD_PERF_CNT_EN defined.
`ifdef HAZARD_PERF_CNT_EN
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Sticks at all-ones instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Load-use bubble, memory-wait freeze and taken-branch squash control beside decode.
// Build option HAZARD_PERF_CNT_EN: implements StallCnt/HoldCnt; otherwise they read 0.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] DecAa,
    input  logic [REG_W-1:0] DecAb,
    input  logic             DecUsesA,
    input  logic             DecUsesB,
    input  logic [REG_W-1:0] ExAw,
    input  logic             ExMemRead,
    input  logic             BrTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IfIdWrite,
    output logic             IdExBubble,
    output logic             IfIdFlush,
    output logic             PipeHold,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] HoldCnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [2:0] FLUSH_FULL = 3'(FLUSH_CYCLES);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    hz_state_t         state_q, state_d;
    logic              br_pend_q, br_pend_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              mem_stall;
    logic              load_use;

    assign mem_stall = MemReq && !MemReady;
    assign load_use  = ExMemRead && (ExAw != XZR) &&
                       ((DecUsesA && (ExAw == DecAa)) || (DecUsesB && (ExAw == DecAb)));

    always_comb begin
        state_d       = state_q;
        br_pend_d     = br_pend_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        PCWrite       = 1'b1;
        IfIdWrite     = 1'b1;
        IdExBubble    = 1'b0;
        IfIdFlush     = 1'b0;
        PipeHold      = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    PCWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    PipeHold    = 1'b1;
                    br_pend_d   = BrTaken;
                    flush_cnt_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = MEM_WAIT;
                end else if (BrTaken) begin
                    IfIdFlush   = 1'b1;
                    IdExBubble  = 1'b1;
                    flush_cnt_d = FLUSH_LAST;
                    if (FLUSH_LAST != 3'd0) begin
                        state_d = FLUSH;
                    end
                end else if (load_use) begin
                    PCWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExBubble = 1'b1;
                end
            end

            MEM_WAIT: begin
                br_pend_d = br_pend_q || BrTaken;
                if (MemReady) begin
                    // A stalled load-use hazard is still pending at release unless a flush follows.
                    wait_cnt_d = '0;
                    br_pend_d  = 1'b0;
                    if (br_pend_q || BrTaken) begin
                        flush_cnt_d = FLUSH_FULL;
                        state_d     = FLUSH;
                    end else if (flush_cnt_q != 3'd0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                        if (load_use) begin
                            PCWrite    = 1'b0;
                            IfIdWrite  = 1'b0;
                            IdExBubble = 1'b1;
                        end
                    end
                end else begin
                    PCWrite   = 1'b0;
                    IfIdWrite = 1'b0;
                    PipeHold  = 1'b1;
                    if (wait_cnt_q != WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WAIT_LIMIT) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end

            FLUSH: begin
                if (mem_stall) begin
                    // Remaining flush count is preserved and resumed after the memory wait.
                    PCWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    PipeHold   = 1'b1;
                    br_pend_d  = BrTaken;
                    wait_cnt_d = '0;
                    state_d    = MEM_WAIT;
                end else begin
                    IfIdFlush   = 1'b1;
                    IdExBubble  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            PCWrite    = 1'b1;
            IfIdWrite  = 1'b1;
            IdExBubble = 1'b0;
            IfIdFlush  = 1'b0;
            PipeHold   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            br_pend_q     <= 1'b0;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            br_pend_q     <= br_pend_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign MemTimeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_inc;
    logic hold_inc;

    // A bubble without a flush is exactly a load-use stall.
    assign stall_inc = IdExBubble && !IfIdFlush;
    assign hold_inc  = (state_q == MEM_WAIT);

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (1'b0),
        .q     (StallCnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hold_inc),
        .clr   (1'b0),
        .q     (HoldCnt)
    );
`else
    assign StallCnt = '0;
    assign HoldCnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl against a flush-debt behavioural model.
module tb_hazard_stall_ctrl;

    localparam int FC  = 3;
    localparam int MW  = 255;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    DecAa = '0, DecAb = '0, ExAw = '0;
    logic          DecUsesA = 1'b0, DecUsesB = 1'b0, ExMemRead = 1'b0;
    logic          BrTaken = 1'b0, MemReq = 1'b0, MemReady = 1'b0;
    logic          PCWrite, IfIdWrite, IdExBubble, IfIdFlush, PipeHold, MemTimeout;
    logic [CW-1:0] StallCnt, HoldCnt;

    int testsRun = 0;
    int testsFailed = 0;

    // Model: flush cycles still owed, whether memory is holding us, and event tallies.
    int mOwed, mWait, mStalls, mHolds;
    bit mHolding, mBrOwed, mTimeout;

    hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .DecAa      (DecAa),
        .DecAb      (DecAb),
        .DecUsesA   (DecUsesA),
        .DecUsesB   (DecUsesB),
        .ExAw       (ExAw),
        .ExMemRead  (ExMemRead),
        .BrTaken    (BrTaken),
        .MemReq     (MemReq),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IfIdWrite  (IfIdWrite),
        .IdExBubble (IdExBubble),
        .IfIdFlush  (IfIdFlush),
        .PipeHold   (PipeHold),
        .MemTimeout (MemTimeout),
        .StallCnt   (StallCnt),
        .HoldCnt    (HoldCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int expCount(input int n);
        if (!PERF) return 0;
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic modelReset();
        mOwed = 0; mWait = 0; mStalls = 0; mHolds = 0;
        mHolding = 1'b0; mBrOwed = 1'b0; mTimeout = 1'b0;
    endtask

    // One pipeline cycle: drive, compare against the model, then let the clock edge land.
    task automatic applyStimulus(input logic [4:0] aa, input logic [4:0] ab, input logic [4:0] aw,
                                 input logic ua, input logic ub, input logic lr,
                                 input logic bt, input logic mq, input logic my);
        bit lu, memStall;
        bit ePc, eIf, eBub, eFl, eHold;
        @(negedge clk);
        DecAa = aa; DecAb = ab; ExAw = aw; DecUsesA = ua; DecUsesB = ub;
        ExMemRead = lr; BrTaken = bt; MemReq = mq; MemReady = my;
        #1;
        checkOutput("memtimeout", MemTimeout, mTimeout);
        checkOutput("stallcnt", StallCnt, expCount(mStalls));
        checkOutput("holdcnt", HoldCnt, expCount(mHolds));

        lu = lr && (aw != 5'd31) && ((ua && aw == aa) || (ub && aw == ab));
        memStall = mq && !my;
        ePc = 1; eIf = 1; eBub = 0; eFl = 0; eHold = 0;
        if (!mHolding) begin
            if (memStall) begin
                ePc = 0; eIf = 0; eHold = 1;
                mHolding = 1; mBrOwed = bt; mWait = 0;
            end else if (mOwed > 0) begin
                eFl = 1; eBub = 1; mOwed--;
            end else if (bt) begin
                eFl = 1; eBub = 1; mOwed = FC - 1;
            end else if (lu) begin
                ePc = 0; eIf = 0; eBub = 1; mStalls++;
            end
        end else begin
            mHolds++;
            if (my) begin
                mHolding = 0; mWait = 0;
                if (mBrOwed || bt) begin
                    mOwed = FC;
                end else if (mOwed == 0 && lu) begin
                    ePc = 0; eIf = 0; eBub = 1; mStalls++;
                end
                mBrOwed = 0;
            end else begin
                ePc = 0; eIf = 0; eHold = 1;
                mBrOwed = mBrOwed || bt;
                if (mWait < MW) mWait++;
                if (mWait == MW) mTimeout = 1;
            end
        end

        checkOutput("pcwrite", PCWrite, ePc);
        checkOutput("ifidwrite", IfIdWrite, eIf);
        checkOutput("idexbubble", IdExBubble, eBub);
        checkOutput("ififlush", IfIdFlush, eFl);
        checkOutput("pipehold", PipeHold, eHold);
        @(posedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge arrives.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_pcwrite", PCWrite, 1'b1);
        checkOutput("rst_ifidwrite", IfIdWrite, 1'b1);
        checkOutput("rst_bubble", IdExBubble, 1'b0);
        checkOutput("rst_flush", IfIdFlush, 1'b0);
        checkOutput("rst_pipehold", PipeHold, 1'b0);
        checkOutput("rst_timeout", MemTimeout, 1'b0);
        checkOutput("rst_stallcnt", StallCnt, 0);
        checkOutput("rst_holdcnt", HoldCnt, 0);
        DecAa = '0; DecAb = '0; ExAw = '0; DecUsesA = 0; DecUsesB = 0;
        ExMemRead = 0; BrTaken = 0; MemReq = 0; MemReady = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    function automatic logic [4:0] pickReg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        modelReset();
        doReset();

        // Load X3 in EX, decode reads X3 as Rn: one bubble, then normal flow.
        applyStimulus(5'd3, 5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle();
        #2 checkOutput("t1_stallcnt", StallCnt, PERF ? 1 : 0);

        // XZR destination never stalls.
        applyStimulus(5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Four hold cycles with a branch arriving mid-wait, then the owed flush.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2 checkOutput("t3_holdcnt", HoldCnt, PERF ? 4 : 0);
        for (int i = 0; i < FC + 1; i++) idleCycle();

        // Branch and load-use together: flush wins, no bubble counted.
        applyStimulus(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FC; i++) idleCycle();
        #2 checkOutput("t4_stallcnt", StallCnt, PERF ? 1 : 0);

        // 256 cycles of waiting reaches the timeout limit.
        for (int i = 0; i < 256; i++)
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 checkOutput("t5_timeout", MemTimeout, 1'b1);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset();

        // Reset in the middle of a memory wait.
        for (int i = 0; i < 3; i++)
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        applyStimulus(5'd5, 5'd2, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a flush.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        doReset();
        applyStimulus(5'd4, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle();

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(pickReg(), pickReg(), pickReg(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if (i % 1000 == 999) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
